// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tristate bus controllers: FSM state codes,
// the round-robin pick function and the all-drivers-off enable pattern.
package tribus_pkg;

  localparam int MAXSRC = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DRIVE  = 2'd2,
    S_DEAD   = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // tinv EN_BAR is active low, so all ones switches every driver off
  localparam logic [MAXSRC-1:0] EN_BAR_OFF = '1;

  // First set bit of req at or above ptr, wrapping at nsrc. The loop runs
  // downward so the smallest offset from ptr is the one left in p.
  function automatic pick_t rr_pick(input logic [MAXSRC-1:0] req,
                                    input logic [2:0]        ptr,
                                    input int                nsrc);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = MAXSRC - 1; k >= 0; k--) begin
      if (k < nsrc) begin
        idx = int'(ptr) + k;
        if (idx >= nsrc) idx = idx - nsrc;
        if (req[idx[2:0]]) begin
          p.found = 1'b1;
          p.idx   = idx[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/tribus_if.sv
// Request/enable/receive signal bundle between tribus_ctl (master) and the
// bus sources plus receiver buffer (slave).
interface tribus_if #(
  parameter int NSRC  = 4,
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(NSRC);

  logic [NSRC-1:0]  req;
  logic [NSRC-1:0]  gnt;
  logic [NSRC-1:0]  en;
  logic [NSRC-1:0]  en_bar;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [SW-1:0]    rx_src;
  logic             busy;

  modport master (
    input  req, bus_in,
    output gnt, en, en_bar, rx_data, rx_valid, rx_src, busy
  );

  modport slave (
    output req, bus_in,
    input  gnt, en, en_bar, rx_data, rx_valid, rx_src, busy
  );
endinterface

// File: rtl/tribus_rr_arb.sv
// Combinational round-robin picker: zero latency, no backpressure; reports the
// first requester at or above ptr_i as one-hot, index and an any flag.
module tribus_rr_arb
  import tribus_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]         req_i,
  input  logic [$clog2(NSRC)-1:0] ptr_i,
  output logic [NSRC-1:0]         oh_o,
  output logic [$clog2(NSRC)-1:0] idx_o,
  output logic                    any_o
);
  localparam int SW = $clog2(NSRC);

  pick_t pick;
  logic  unused_idx;

  assign pick       = rr_pick(MAXSRC'(req_i), 3'(ptr_i), NSRC);
  assign any_o      = pick.found;
  assign idx_o      = pick.idx[SW-1:0];
  assign oh_o       = pick.found ? (NSRC'(1) << pick.idx) : '0;
  assign unused_idx = ^pick.idx;

endmodule

// File: rtl/tribus_ctl.sv
// Tristate bus owner arbiter with break-before-make dead time; grant is one edge
// after REQ, captures start two edges after grant; REQ is ignored outside IDLE.
module tribus_ctl
  import tribus_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int WIDTH   = 8,
  parameter int DEAD    = 2,
  parameter int MAXHOLD = 16
) (
  input  logic     clk_i,
  input  logic     rn_i,
  tribus_if.master bus
);
  localparam int SW = $clog2(NSRC);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int DW = $clog2(DEAD + 1);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_SETTLE = S_SETTLE;
  localparam logic [1:0] ST_DRIVE  = S_DRIVE;
  localparam logic [1:0] ST_DEAD   = S_DEAD;

  logic [1:0]       state_q,    state_d;
  logic [SW-1:0]    owner_q,    owner_d;
  logic [SW-1:0]    rr_q,       rr_d;
  logic [HW-1:0]    hold_q,     hold_d;
  logic [DW-1:0]    dead_q,     dead_d;
  logic [NSRC-1:0]  en_q,       en_d;
  logic [NSRC-1:0]  en_bar_q;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic [SW-1:0]    rx_src_q,   rx_src_d;
  logic             rx_valid_q, rx_valid_d;

  logic [NSRC-1:0]  arb_oh;
  logic [SW-1:0]    arb_idx;
  logic             arb_any;

  tribus_rr_arb #(.NSRC(NSRC)) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .oh_o  (arb_oh),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    hold_d     = hold_q;
    dead_d     = dead_q;
    en_d       = en_q;
    rx_data_d  = rx_data_q;
    rx_src_d   = rx_src_q;
    rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          en_d    = arb_oh;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        hold_d  = HW'(1);
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (bus.req[owner_q] && (hold_q < HW'(MAXHOLD))) begin
          rx_data_d  = bus.bus_in;
          rx_src_d   = owner_q;
          rx_valid_d = 1'b1;
          hold_d     = hold_q + 1'b1;
        end else begin
          // Release and hand priority to the next source in the ring
          en_d    = '0;
          rr_d    = (owner_q == SW'(NSRC - 1)) ? '0 : owner_q + 1'b1;
          dead_d  = DW'(DEAD);
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        dead_d = dead_q - 1'b1;
        if (dead_q == DW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      hold_q     <= '0;
      dead_q     <= '0;
      en_q       <= '0;
      en_bar_q   <= EN_BAR_OFF[NSRC-1:0];
      rx_data_q  <= '0;
      rx_src_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      dead_q     <= dead_d;
      en_q       <= en_d;
      en_bar_q   <= ~en_d;
      rx_data_q  <= rx_data_d;
      rx_src_q   <= rx_src_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.gnt      = en_q;
  assign bus.en       = en_q;
  assign bus.en_bar   = en_bar_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_src   = rx_src_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tribus_ctl.sv
// Bench for tribus_ctl: directed scenarios plus random REQ traffic, all checked
// each cycle against a transaction-level ownership model.
module tb_tribus_ctl;
  localparam int NSRC    = 4;
  localparam int WIDTH   = 8;
  localparam int DEAD    = 2;
  localparam int MAXHOLD = 16;
  localparam int SW      = $clog2(NSRC);

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  tribus_if #(.NSRC(NSRC), .WIDTH(WIDTH)) bif ();

  tribus_ctl #(.NSRC(NSRC), .WIDTH(WIDTH), .DEAD(DEAD), .MAXHOLD(MAXHOLD)) dut (
    .clk_i (clk),
    .rn_i  (rn),
    .bus   (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Ownership model: who owns the bus, edges since grant, captures so far,
  // and how many edges of enforced all-off time remain.
  int               m_owner = -1;
  int               m_rr    = 0;
  int               m_cool  = 0;
  int               m_age   = 0;
  int               m_caps  = 0;
  logic             m_vld   = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_src   = 0;

  function automatic int pick(input logic [NSRC-1:0] r, input int rr);
    for (int k = 0; k < NSRC; k++)
      if (r[(rr + k) % NSRC]) return (rr + k) % NSRC;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NSRC-1:0] v);
    for (int k = 0; k < NSRC; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) begin : scoreboard
    logic [NSRC-1:0]  rq;
    logic [WIDTH-1:0] bw;
    logic [NSRC-1:0]  exp_en;
    logic             exp_busy;
    rq    = bif.req;
    bw    = bif.bus_in;
    m_vld = 1'b0;
    if (!rn) begin
      m_owner = -1; m_rr = 0; m_cool = 0; m_data = '0; m_src = 0;
    end else if (m_owner < 0) begin
      if (m_cool > 0) m_cool--;
      else if (rq != '0) begin
        m_owner = pick(rq, m_rr); m_age = 0; m_caps = 0;
      end
    end else begin
      m_age++;
      if (m_age > 1) begin
        if (rq[m_owner] && m_caps < MAXHOLD - 1) begin
          m_caps++; m_vld = 1'b1; m_data = bw; m_src = m_owner;
        end else begin
          m_rr = (m_owner + 1) % NSRC; m_owner = -1; m_cool = DEAD;
        end
      end
    end
    #1;
    if (rn) begin
      exp_en   = (m_owner >= 0) ? (NSRC'(1) << m_owner) : '0;
      exp_busy = (m_owner >= 0) || (m_cool > 0);
      n_tests++;
      if (bif.en !== exp_en) begin
        n_fail++; $display("FAIL sb_en t=%0t got %b want %b", $time, bif.en, exp_en);
      end
      n_tests++;
      if (bif.en_bar !== ~exp_en) begin
        n_fail++; $display("FAIL sb_en_bar t=%0t got %b want %b", $time, bif.en_bar, ~exp_en);
      end
      n_tests++;
      if (bif.gnt !== exp_en) begin
        n_fail++; $display("FAIL sb_gnt t=%0t got %b want %b", $time, bif.gnt, exp_en);
      end
      n_tests++;
      if (bif.busy !== exp_busy) begin
        n_fail++; $display("FAIL sb_busy t=%0t got %b want %b", $time, bif.busy, exp_busy);
      end
      n_tests++;
      if (bif.rx_valid !== m_vld) begin
        n_fail++; $display("FAIL sb_rx_valid t=%0t got %b want %b", $time, bif.rx_valid, m_vld);
      end
      n_tests++;
      if (bif.rx_data !== m_data || bif.rx_src !== SW'(m_src)) begin
        n_fail++;
        $display("FAIL sb_rx t=%0t got %h/%0d want %h/%0d", $time, bif.rx_data, bif.rx_src,
                 m_data, m_src);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    bif.bus_in = WIDTH'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk); rn = 1'b0;
    @(posedge clk);
    @(negedge clk); rn = 1'b1;
    #6;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bif.req = '0;
    while (bif.busy !== 1'b0 && n < 50) begin cyc(); n++; end
    n_tests++;
    if (bif.busy !== 1'b0) begin
      n_fail++; $display("FAIL wait_idle timeout busy=%b", bif.busy);
    end
  endtask

  task automatic test_reset();
    rn = 1'b0; bif.req = '0; bif.bus_in = '0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (bif.en !== '0 || bif.gnt !== '0 || bif.en_bar !== {NSRC{1'b1}}) begin
      n_fail++; $display("FAIL reset_en en=%b gnt=%b en_bar=%b want 0/0/1s", bif.en, bif.gnt, bif.en_bar);
    end
    n_tests++;
    if (bif.rx_data !== '0 || bif.rx_valid !== 1'b0 || bif.rx_src !== '0 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx data=%h vld=%b src=%0d busy=%b want all 0", bif.rx_data,
               bif.rx_valid, bif.rx_src, bif.busy);
    end
    @(negedge clk); rn = 1'b1;
    #6;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] words [6];
    int caps;
    words = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0};
    caps  = 0;
    wait_idle();
    bif.req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      bif.bus_in = words[c];
      @(posedge clk); #2;
      if (c == 0) begin
        n_tests++;
        if (bif.en !== 4'b0001) begin
          n_fail++; $display("FAIL single_grant en=%b want 0001", bif.en);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (bif.rx_valid !== 1'b0) begin
          n_fail++; $display("FAIL single_settle rx_valid=%b want 0", bif.rx_valid);
        end
      end
      if (bif.rx_valid === 1'b1) begin
        caps++;
        n_tests++;
        if (bif.rx_src !== '0 || bif.rx_data !== words[c]) begin
          n_fail++;
          $display("FAIL single_word src=%0d data=%h want 0/%h", bif.rx_src, bif.rx_data, words[c]);
        end
      end
    end
    bif.req = '0;
    for (int c = 0; c < DEAD + 1; c++) begin
      cyc();
      n_tests++;
      if (bif.en !== '0 || bif.en_bar !== {NSRC{1'b1}}) begin
        n_fail++; $display("FAIL single_dead en=%b en_bar=%b want 0000/1111", bif.en, bif.en_bar);
      end
    end
    n_tests++;
    if (caps !== 5 - 2) begin
      n_fail++; $display("FAIL single_caps got %0d want %0d", caps, 5 - 2);
    end
  endtask

  task automatic test_round_robin();
    logic [NSRC-1:0] prev_en;
    int k, off, n;
    do_reset();
    bif.req = '1;
    prev_en = bif.en;
    k = 0; off = 0; n = 0;
    while (k < 5 && n < 200) begin
      cyc(); n++;
      if (bif.en === '0) off++;
      else if (prev_en === '0) begin
        n_tests++;
        if (oh_idx(bif.en) !== k % NSRC) begin
          n_fail++; $display("FAIL rr_order grant %0d got src %0d want %0d", k, oh_idx(bif.en), k % NSRC);
        end
        if (k > 0) begin
          n_tests++;
          if (off !== DEAD + 1) begin
            n_fail++; $display("FAIL rr_gap got %0d off cycles want %0d", off, DEAD + 1);
          end
        end
        off = 0; k++;
      end
      prev_en = bif.en;
      bif.req = bif.rx_valid ? ~(NSRC'(1) << bif.rx_src) : '1;
    end
    n_tests++;
    if (k !== 5) begin
      n_fail++; $display("FAIL rr_timeout grants got %0d want 5", k);
    end
    bif.req = '0;
  endtask

  task automatic test_forced_release();
    logic [NSRC-1:0] prev_en;
    int caps, grants;
    wait_idle();
    bif.req = 4'b0100;
    prev_en = '0; caps = 0; grants = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (bif.en !== '0 && prev_en === '0) begin
        grants++;
        n_tests++;
        if (bif.en !== 4'b0100) begin
          n_fail++; $display("FAIL forced_grant en=%b want 0100", bif.en);
        end
      end
      if (bif.rx_valid === 1'b1 && grants == 1) caps++;
      prev_en = bif.en;
    end
    n_tests++;
    if (caps !== MAXHOLD - 1) begin
      n_fail++; $display("FAIL forced_caps got %0d want %0d", caps, MAXHOLD - 1);
    end
    n_tests++;
    if (grants < 2) begin
      n_fail++; $display("FAIL forced_regrant grants got %0d want >=2", grants);
    end
    bif.req = '0;
  endtask

  task automatic test_early_drop();
    int pulses;
    wait_idle();
    bif.req = 4'b0010;
    cyc();
    bif.req = '0;
    n_tests++;
    if (bif.en !== 4'b0010) begin
      n_fail++; $display("FAIL drop_grant en=%b want 0010", bif.en);
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (bif.rx_valid === 1'b1) pulses++;
      if (c == 1) begin
        n_tests++;
        if (bif.en !== '0) begin
          n_fail++; $display("FAIL drop_release en=%b want 0000", bif.en);
        end
      end
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL drop_pulses got %0d want 0", pulses);
    end
    wait_idle();
    bif.req = 4'b0101;
    cyc();
    n_tests++;
    if (bif.en !== 4'b0100) begin
      n_fail++; $display("FAIL drop_rr_ptr en=%b want 0100", bif.en);
    end
    bif.req = '0;
  endtask

  task automatic test_late_joiner();
    int n;
    wait_idle();
    bif.req = 4'b0001;
    n = 0;
    while (bif.rx_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    bif.req = 4'b1001;
    n = 0;
    while (bif.en !== '0 && n < 40) begin
      n_tests++;
      if (bif.en !== 4'b0001) begin
        n_fail++; $display("FAIL late_hold en=%b want 0001", bif.en);
      end
      cyc(); n++;
    end
    n = 0;
    while (bif.en === '0 && n < 20) begin cyc(); n++; end
    n_tests++;
    if (bif.en !== 4'b1000) begin
      n_fail++; $display("FAIL late_grant en=%b want 1000", bif.en);
    end
    bif.req = '0;
  endtask

  task automatic test_reset_mid_drive();
    int n;
    wait_idle();
    bif.req = 4'b0100;
    n = 0;
    while (bif.rx_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    #1 rn = 1'b0;
    #1;
    n_tests++;
    if (bif.en !== '0 || bif.gnt !== '0 || bif.en_bar !== {NSRC{1'b1}}) begin
      n_fail++; $display("FAIL midrst_en en=%b gnt=%b en_bar=%b want 0/0/1s", bif.en, bif.gnt, bif.en_bar);
    end
    n_tests++;
    if (bif.busy !== 1'b0 || bif.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stat busy=%b rx_valid=%b want 0/0", bif.busy, bif.rx_valid);
    end
    @(posedge clk);
    @(negedge clk);
    bif.req = '0;
    rn = 1'b1;
    #6;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      cyc();
      if ($urandom_range(0, 3) == 0) bif.req = NSRC'($urandom) & NSRC'($urandom);
    end
    bif.req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_forced_release();
    test_early_drop();
    test_late_joiner();
    test_reset_mid_drive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tribus_ctl.md
Name: tribus_ctl

Overview:
- Controller for a shared multi-bit tristate bus built from tinv_4 driver cells: one EN/EN_BAR pair per source.
- Arbitrates up to NSRC requesters round-robin and drives the winner's enable pair.
- Enforces break-before-make dead time between owners.
- On the receive side, registers the resolved bus value and tags it with the source index.

Parameters:
- NSRC, 4, number of bus sources (2..8).
- WIDTH, 8, bus width seen on BUS_IN / RX_DATA.
- DEAD, 2, all-off cycles between ownership changes (>=1).
- MAXHOLD, 16, maximum DRIVE cycles before forced release (>=2).
- SW, $clog2(NSRC), source index width (derived; not overridable).

Ports:
- CLK  input  1  clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- REQ  input  NSRC  per-source bus request; level, held for the transfer.
- GNT  output  NSRC  one-hot grant, registered.
- EN  output  NSRC  tinv enable to each source driver, registered.
- EN_BAR  output  NSRC  complement enable, registered.
- BUS_IN  input  WIDTH  resolved bus value from the receiver buffer.
- RX_DATA  output  WIDTH  captured bus word.
- RX_VALID  output  1  RX_DATA valid this cycle (one-cycle pulse per capture).
- RX_SRC  output  SW  index of the source that drove RX_DATA.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RN low, asynchronous, any state):
  - GNT=0, EN=0, EN_BAR=all 1s (all drivers off).
  - RX_DATA=0, RX_VALID=0, RX_SRC=0, BUSY=0.
  - state=IDLE, rr pointer=0, hold counter=0.
- Reset deassertion is synchronised externally; the first active edge after RN rises behaves as IDLE.
- Invariants, every cycle:
  - EN[i]==~EN_BAR[i] for every i.
  - popcount(EN)<=1; GNT==EN.
  - No cycle exists in which two sources are enabled, including across ownership changes.
- States: IDLE, SETTLE, DRIVE, DEAD.
- IDLE:
  - If REQ!=0, select the first set bit searching from rr pointer upward with wrap.
  - At that edge: owner<=winner, GNT/EN[winner]<=1, EN_BAR[winner]<=0, BUSY<=1, next state SETTLE.
  - If REQ==0, stay in IDLE.
- SETTLE (exactly 1 cycle): bus settling; no capture. Next state DRIVE, hold counter<=1.
- DRIVE:
  - Each edge with REQ[owner]=1 and hold<MAXHOLD: RX_DATA<=BUS_IN, RX_SRC<=owner, RX_VALID<=1, hold<=hold+1.
  - Release conditions: REQ[owner]=0, or hold==MAXHOLD.
  - On release at that edge: EN/GNT<=0, EN_BAR<=all 1s, RX_VALID<=0, rr<=owner+1 mod NSRC, dead counter<=DEAD, next state DEAD.
  - The MAXHOLD release edge does not capture. Maximum captures per grant = MAXHOLD-1.
- DEAD:
  - Decrement the dead counter each edge.
  - When it reaches 1, the next state is IDLE.
  - REQ is ignored in DEAD. Minimum all-off interval is DEAD cycles plus the IDLE arbitration edge.
- RX_VALID is 0 in every cycle not immediately following a DRIVE capture edge.
- RX_DATA and RX_SRC hold their last value otherwise.
- Requester behaviour:
  - A requester that drops REQ during SETTLE is still granted SETTLE, then released on the first DRIVE edge with zero captures.
  - A requester that re-requests after a forced release competes behind the other requesters (rr advanced).
- Simultaneous events:
  - REQ changes of non-owners during SETTLE/DRIVE/DEAD have no effect until IDLE.
  - Single requester: re-granted after DEAD+1 cycles.
- hold counter is $clog2(MAXHOLD+1) bits and never wraps.

Decomposition:
- Shared package tribus_pkg:
  - state enum (IDLE, SETTLE, DRIVE, DEAD).
  - function rr_pick(req, ptr) returning the index and a found flag.
  - localparam for the all-off EN_BAR pattern.
- One sub-module, tribus_rr_arb: combinational round-robin picker (REQ, ptr -> one-hot, index, any). It is reused by other bus controllers.
- FSM, counters and RX capture stay in tribus_ctl.

Test Plan:
- Reset mid-DRIVE: source 2 owning, pull RN low between edges -> EN=0000 and EN_BAR=1111 immediately (no clock), BUSY=0, RX_VALID=0.
- Single transfer: REQ=0001 held 5 cycles, BUS_IN=0xA5,0x3C,... -> EN=0001 one edge later, SETTLE cycle without capture, RX_VALID pulses with RX_SRC=0 and matching words, then DEAD=2 all-off cycles.
- Round-robin fairness: REQ=1111 continuously, 1-cycle transfers -> grant order 0,1,2,3,0; never two EN bits set; gap between owners >= DEAD+1 cycles of EN=0000.
- Forced release: REQ=0100 held 40 cycles, MAXHOLD=16 -> exactly 15 captures, release, DEAD, re-grant to source 2 (sole requester).
- Early drop: REQ[1] pulses 1 cycle only -> SETTLE, then immediate release with zero RX_VALID pulses; rr pointer=2.
- Late joiner: source 3 raises REQ during source 0's DRIVE -> no effect until IDLE, then granted ahead of source 0 (rr=1 search finds 3 first if 1 and 2 idle).
